// File: rtl/cnn_pkg.sv
// Shared types and default widths for the input-feature fetch controller.
// Included by every file of the fetch block through import cnn_pkg::*.
package cnn_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 12;
  localparam int NUM_CH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FETCH = 2'd2,
    S_DONE  = 2'd3
  } if_fetch_state_t;

endpackage

// File: rtl/if_addr_gen.sv
// Channel/element walker: base + c*stride + k built by adding stride at channel edges, one step per adv_i.
// Zero-latency view of registered address; holds everything while adv_i is low.
module if_addr_gen
  import cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [CH_W:0]     num_ch_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              last_o
);

  logic [LEN_W-1:0]  len_q, len_d;
  logic [CH_W:0]     num_q, num_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [CH_W-1:0]   c_q, c_d;
  logic              last_q, last_d;
  logic              k_end;

  assign k_end = (k_q == len_q - LEN_W'(1));

  // last_q is precomputed for the element about to be presented, so rd_last is a pure register.
  always_comb begin
    len_d    = len_q;
    num_d    = num_q;
    stride_d = stride_q;
    base_d   = base_q;
    addr_d   = addr_q;
    k_d      = k_q;
    c_d      = c_q;
    last_d   = last_q;
    if (load_i) begin
      len_d    = len_i;
      num_d    = num_ch_i;
      stride_d = stride_i;
      base_d   = base_i;
      addr_d   = base_i;
      k_d      = '0;
      c_d      = '0;
      last_d   = (len_i == LEN_W'(1)) && (num_ch_i == (CH_W+1)'(1));
    end else if (adv_i) begin
      if (k_end) begin
        k_d    = '0;
        c_d    = c_q + CH_W'(1);
        base_d = base_q + stride_q;
        addr_d = base_q + stride_q;
        last_d = (len_q == LEN_W'(1)) && (({1'b0, c_q} + (CH_W+1)'(2)) == num_q);
      end else begin
        k_d    = k_q + LEN_W'(1);
        addr_d = addr_q + ADDR_W'(1);
        last_d = ((k_q + LEN_W'(2)) == len_q) && (({1'b0, c_q} + (CH_W+1)'(1)) == num_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      num_q    <= '0;
      stride_q <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      k_q      <= '0;
      c_q      <= '0;
      last_q   <= 1'b0;
    end else begin
      len_q    <= len_d;
      num_q    <= num_d;
      stride_q <= stride_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      c_q      <= c_d;
      last_q   <= last_d;
    end
  end

  assign addr_o = addr_q;
  assign ch_o   = c_q;
  assign last_o = last_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF fetch FSM: one CLEAR cycle, then len*num_ch reads, then a one-cycle if_done (start-to-done 2+len*num_ch).
// Reads stall in place while mem_ready is low; abort drops back to IDLE without if_done.
module if_fetch_ctrl
  import cnn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_if,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] ch_stride,
  input  logic [CH_W:0]     num_ch,
  input  logic              mem_ready,
  input  logic              abort,
  output logic              if_ready,
  output logic              if_read,
  output logic              clr_if,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CH_W-1:0]   rd_ch,
  output logic              rd_last,
  output logic              if_done
);

  if_fetch_state_t state_q, state_d;

  logic [CH_W:0]     num_eff;
  logic              zero_job;
  logic              start_ok;
  logic              load;
  logic              xfer;
  logic [ADDR_W-1:0] ag_addr;
  logic [CH_W-1:0]   ag_ch;
  logic              ag_last;

  assign num_eff  = (num_ch > (CH_W+1)'(NUM_CH)) ? (CH_W+1)'(NUM_CH) : num_ch;
  assign zero_job = (len == '0) || (num_eff == '0);
  assign start_ok = (state_q == S_IDLE) && start_if && !abort;
  assign load     = start_ok && !zero_job;
  assign xfer     = (state_q == S_FETCH) && mem_ready && !abort;

  if_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .NUM_CH (NUM_CH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .adv_i    (xfer),
    .base_i   (base_addr),
    .stride_i (ch_stride),
    .len_i    (len),
    .num_ch_i (num_eff),
    .addr_o   (ag_addr),
    .ch_o     (ag_ch),
    .last_o   (ag_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = zero_job ? S_DONE : S_CLEAR;
      S_CLEAR: state_d = abort ? S_IDLE : S_FETCH;
      S_FETCH: begin
        if (abort)                state_d = S_IDLE;
        else if (xfer && ag_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read-side fields are forced to zero outside FETCH so idle outputs never show stale job state.
  always_comb begin
    if_ready = (state_q == S_IDLE);
    clr_if   = (state_q == S_CLEAR);
    if_read  = (state_q == S_FETCH);
    if_done  = (state_q == S_DONE);
    rd_addr  = (state_q == S_FETCH) ? ag_addr : '0;
    rd_ch    = (state_q == S_FETCH) ? ag_ch   : '0;
    rd_last  = (state_q == S_FETCH) && ag_last;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboarded bench for if_fetch_ctrl: driver queues expected reads/pulses, negedge monitor checks them.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_if = 1'b0;
  logic [15:0] base_addr = '0;
  logic [11:0] len = '0;
  logic [15:0] ch_stride = '0;
  logic [2:0]  num_ch = '0;
  logic        mem_ready = 1'b0;
  logic        abort = 1'b0;
  logic        if_ready, if_read, clr_if, rd_last, if_done;
  logic [15:0] rd_addr;
  logic [1:0]  rd_ch;

  typedef struct {
    logic [15:0] a;
    logic [1:0]  ch;
    logic        l;
  } rd_t;

  rd_t exp_q[$];
  int  done_q[$];
  int  clr_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  rd_t mon_e;

  if_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_if  (start_if),
    .base_addr (base_addr),
    .len       (len),
    .ch_stride (ch_stride),
    .num_ch    (num_ch),
    .mem_ready (mem_ready),
    .abort     (abort),
    .if_ready  (if_ready),
    .if_read   (if_read),
    .clr_if    (clr_if),
    .rd_addr   (rd_addr),
    .rd_ch     (rd_ch),
    .rd_last   (rd_last),
    .if_done   (if_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_ready"}, if_ready, 1);
    chk({tag, "_if_read"},  if_read,  0);
    chk({tag, "_clr_if"},   clr_if,   0);
    chk({tag, "_if_done"},  if_done,  0);
    chk({tag, "_rd_last"},  rd_last,  0);
    chk({tag, "_rd_addr"},  rd_addr,  0);
    chk({tag, "_rd_ch"},    rd_ch,    0);
  endtask

  // Every FETCH cycle is compared against the head element, so a stall must keep it unchanged.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_read) begin
        if (exp_q.size() == 0) chk("rd_unexpected", if_read, 0);
        else begin
          mon_e = exp_q[0];
          chk("rd_addr", rd_addr, mon_e.a);
          chk("rd_ch",   rd_ch,   mon_e.ch);
          chk("rd_last", rd_last, mon_e.l);
          if (mem_ready) void'(exp_q.pop_front());
        end
      end
      if (if_done) begin
        if (done_q.size() == 0) chk("done_unexpected", if_done, 0);
        else begin
          chk("done_cycle", cyc, done_q.pop_front());
          chk("done_not_ready", if_ready, 0);
        end
      end
      if (clr_if) begin
        if (clr_q.size() == 0) chk("clr_unexpected", clr_if, 0);
        else chk("clr_cycle", cyc, clr_q.pop_front());
      end
    end
  end

  // kind: 0 normal, 1 abort on FETCH cycle kill_at, 2 reset pulse on FETCH cycle kill_at.
  task automatic run_job(input logic [15:0] b, input logic [11:0] l, input logic [15:0] st,
                         input logic [2:0] nc, input int pct, input int stall_pos,
                         input int stall_n, input int kind, input int kill_at);
    int   ne, n, f, ones, held, s;
    logic r;
    bit   killed;
    rd_t  e;
    ne = (nc > 3'd4) ? 4 : int'(nc);
    n  = int'(l) * ne;
    for (int c = 0; c < ne; c++) begin
      for (int k = 0; k < int'(l); k++) begin
        e.a  = 16'(int'(b) + c * int'(st) + k);
        e.ch = 2'(c);
        e.l  = (c == ne - 1) && (k == int'(l) - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    base_addr = b; len = l; ch_stride = st; num_ch = nc; start_if = 1'b1;
    s = cyc;
    if (n == 0) done_q.push_back(s + 1);
    else        clr_q.push_back(s + 1);
    @(posedge clk); #1;
    start_if  = 1'b0;
    mem_ready = 1'($urandom);
    if (n == 0) begin
      @(posedge clk); #1;
      chk("ready_after_zero_job", if_ready, 1);
      chk("zero_job_done_seen", done_q.size(), 0);
      return;
    end
    ones = 0; f = 0; held = 0; killed = 0;
    while (ones < n && !killed) begin
      @(posedge clk); #1;
      r = ($urandom_range(99) >= pct);
      if (ones == stall_pos && held < stall_n) begin
        r = 1'b0;
        held++;
      end
      if (kind != 0 && f == kill_at) begin
        mem_ready = 1'b0;
        if (kind == 1) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort_idle", if_ready, 1);
          chk("abort_no_read", if_read, 0);
        end else begin
          #2 rst = 1'b1;
          #1 chk_reset_outputs("mid_rst");
          @(posedge clk); #1;
          rst = 1'b0;
        end
        exp_q.delete();
        clr_q.delete();
        done_q.delete();
        killed = 1;
      end else begin
        mem_ready = r;
        if (r) ones++;
        f++;
      end
    end
    if (killed) begin
      @(posedge clk); #1;
      chk("idle_after_kill", if_ready, 1);
      return;
    end
    done_q.push_back(s + 2 + f);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_done", if_ready, 1);
    chk("reads_drained", exp_q.size(), 0);
    chk("done_seen", done_q.size(), 0);
    chk("clr_seen", clr_q.size(), 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_out_of_reset", if_ready, 1);

    run_job(16'h0100, 12'd3, 16'h0040, 3'd2, 0, -1, 0, 0, -1);
    run_job(16'h0100, 12'd3, 16'h0040, 3'd2, 0,  4, 3, 0, -1);
    run_job(16'h0500, 12'd0, 16'h0040, 3'd2, 0, -1, 0, 0, -1);
    run_job(16'h0500, 12'd2, 16'h0040, 3'd0, 0, -1, 0, 0, -1);
    run_job(16'h2000, 12'd2, 16'h0010, 3'd7, 0, -1, 0, 0, -1);
    run_job(16'hFFFE, 12'd4, 16'h1234, 3'd1, 0, -1, 0, 0, -1);
    run_job(16'h0300, 12'd4, 16'h0020, 3'd2, 0, -1, 0, 1,  1);

    @(posedge clk); #1;
    start_if = 1'b1; abort = 1'b1; base_addr = 16'h0700; len = 12'd3; num_ch = 3'd1;
    @(posedge clk); #1;
    start_if = 1'b0; abort = 1'b0;
    chk("start_abort_idle", if_ready, 1);
    chk("start_abort_no_clr", clr_if, 0);
    @(posedge clk); #1;
    chk("start_abort_still_idle", if_ready, 1);

    run_job(16'h0400, 12'd8, 16'h0008, 3'd1, 0, -1, 0, 2,  3);
    run_job(16'h0100, 12'd3, 16'h0040, 3'd2, 0, -1, 0, 0, -1);

    for (int j = 0; j < 25; j++) begin
      run_job(16'($urandom), 12'($urandom_range(6)), 16'($urandom),
              3'($urandom_range(7)), 30, -1, 0, 0, -1);
    end

    chk("final_reads_drained", exp_q.size(), 0);
    chk("final_done_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: read-address width.
REQ-002 SHALL have parameter LEN_W, default 12: per-channel element-count width.
REQ-003 SHALL have parameter NUM_CH, default 4: maximum number of input-feature channels; CH_W = $clog2(NUM_CH).
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port start_if, input, 1: start request, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_W: channel-0 start address, latched at start.
REQ-008 SHALL have port len, input, LEN_W: elements per channel, latched at start.
REQ-009 SHALL have port ch_stride, input, ADDR_W: address step between channel bases, latched at start.
REQ-010 SHALL have port num_ch, input, CH_W+1: active channel count, latched at start.
REQ-011 SHALL have port mem_ready, input, 1: memory accepts the current read.
REQ-012 SHALL have port abort, input, 1: cancel the current job.
REQ-013 SHALL have port if_ready, output, 1: idle and able to accept start_if.
REQ-014 SHALL have port if_read, output, 1: read request valid.
REQ-015 SHALL have port clr_if, output, 1: clears the IF buffer.
REQ-016 SHALL have port rd_addr, output, ADDR_W: address of the current read.
REQ-017 SHALL have port rd_ch, output, CH_W: channel of the current read.
REQ-018 SHALL have port rd_last, output, 1: the current read is the final read of the job.
REQ-019 SHALL have port if_done, output, 1: one-cycle job-completion pulse.

Function
REQ-020 SHALL implement states IDLE, CLEAR, FETCH, DONE, with all outputs registered or decoded from registered state only.
REQ-021 IDLE: if_ready=1 and all other outputs 0; on start_if, SHALL latch the configuration and go to CLEAR, or go directly to DONE when len==0 or num_ch==0.
REQ-022 CLEAR: SHALL last exactly one cycle with clr_if=1 and if_read=0, then go to FETCH.
REQ-023 FETCH: SHALL hold if_read=1; a transfer occurs on a cycle where if_read and mem_ready are both 1.
REQ-024 While mem_ready=0, rd_addr, rd_ch and rd_last SHALL hold stable.
REQ-025 Element k of channel c SHALL be read at address base_addr + c*ch_stride + k, computed incrementally without a multiplier, with addresses wrapping modulo 2^ADDR_W.
REQ-026 On a transfer with k==len-1, k SHALL reset to 0 and c SHALL increment; rd_last=1 only for k==len-1 and c==num_ch_eff-1.
REQ-027 The transfer with rd_last=1 SHALL move the state to DONE.
REQ-028 DONE: SHALL last exactly one cycle with if_done=1 and if_ready=0, then return to IDLE.
REQ-029 With mem_ready held at 1, latency from the start_if sample to the if_done pulse SHALL be 2 + len*num_ch_eff cycles.
REQ-030 num_ch greater than NUM_CH SHALL be clamped to NUM_CH (num_ch_eff).
REQ-031 start_if SHALL be ignored outside IDLE.
REQ-032 abort in CLEAR or FETCH SHALL return the state to IDLE on the next edge with no if_done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-033 abort and start_if asserted together in IDLE: abort SHALL win and the state SHALL remain IDLE.

Reset
REQ-034 On rst assertion the block SHALL enter IDLE immediately: if_ready=1; if_read, clr_if, rd_last, if_done=0; rd_addr, rd_ch and all counters 0.
REQ-035 rst mid-job SHALL discard the job with no if_done pulse; the first start_if after rst deassertion SHALL be honoured.

Structure
REQ-036 cnn_pkg SHALL hold the if_fetch_state_t enum and the default ADDR_W, LEN_W and NUM_CH constants.
REQ-037 A single sub-module, if_addr_gen, SHALL own the k and c counters, the channel-base and address registers, and rd_last generation; the FSM SHALL be in if_fetch_ctrl.

Verification
REQ-038 base=0x100, stride=0x40, len=3, num_ch=2, mem_ready=1: addresses 0x100, 0x101, 0x102, 0x140, 0x141, 0x142; rd_ch 0,0,0,1,1,1; rd_last on 0x142 only; if_done 8 cycles after start.
REQ-039 Same job with mem_ready=0 for 3 cycles at 0x141: 0x141 held for 4 cycles, if_read stays 1, if_done delayed by exactly 3 cycles.
REQ-040 len=0 -> no clr_if, no if_read, if_done on the next cycle, if_ready after 2 cycles; num_ch=7 with NUM_CH=4 -> exactly 4 channels read.
REQ-041 base=0xFFFE, len=4, num_ch=1 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-042 abort on the 2nd FETCH cycle -> IDLE next cycle, no if_done; abort and start together in IDLE -> remains IDLE.
REQ-043 rst pulsed mid-FETCH -> outputs take reset values asynchronously; a following job runs correctly from CLEAR.
